// File: rtl/accum_cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC sequencer for the 8-bit accumulator CPU.
// Handles data-memory wait states with a timeout, plus halt and sticky status.
module accum_cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [3:0]          opcode,
  input  logic                acc_zero,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_src,
  output logic                ld_ac,
  output logic                ac_src,
  output logic [2:0]          alu_op,
  output logic                mReadFlag,
  output logic                mWriteFlag,
  output logic [2:0]          state,
  output logic                halted,
  output logic                illegal,
  output logic                bus_error,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_HLT = 4'hF;

  state_t                state_reg, state_next;
  logic [7:0]            wait_cnt_reg;
  logic                  illegal_reg, bus_error_reg;
  logic [RETIRE_W-1:0]   retired_reg;

  logic boundary, retire_en, set_illegal, set_bus_error, wait_clr, wait_inc;

  always_comb begin
    state_next    = state_reg;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_src        = 1'b0;
    ld_ac         = 1'b0;
    ac_src        = 1'b0;
    alu_op        = 3'b000;
    mReadFlag     = 1'b0;
    mWriteFlag    = 1'b0;
    boundary      = 1'b0;
    retire_en     = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    wait_clr      = 1'b0;
    wait_inc      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        ir_load    = 1'b1;
        pc_inc     = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: begin
            boundary  = 1'b1;
            retire_en = 1'b1;
          end
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            wait_clr   = 1'b1;
            state_next = S_MEM;
          end
          OP_NOT: state_next = S_EXEC;
          OP_JMP: begin
            pc_src    = 1'b1;
            boundary  = 1'b1;
            retire_en = 1'b1;
          end
          OP_JZ: begin
            pc_src    = acc_zero;
            boundary  = 1'b1;
            retire_en = 1'b1;
          end
          OP_HLT: begin
            retire_en  = 1'b1;
            state_next = S_HALT;
          end
          default: begin
            set_illegal = 1'b1;
            boundary    = 1'b1;
            retire_en   = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mWriteFlag = (opcode == OP_STA);
        mReadFlag  = (opcode != OP_STA);
        // A completion in the final allowed cycle takes priority over the timeout.
        if (mem_ready) begin
          if (opcode == OP_STA) begin
            boundary  = 1'b1;
            retire_en = 1'b1;
          end else begin
            state_next = S_EXEC;
          end
        end else if (wait_cnt_reg == 8'(MEM_TIMEOUT)) begin
          set_bus_error = 1'b1;
          state_next    = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_EXEC: begin
        ld_ac     = 1'b1;
        ac_src    = (opcode != OP_LDA);
        boundary  = 1'b1;
        retire_en = 1'b1;
        case (opcode)
          OP_SUB:  alu_op = 3'b001;
          OP_AND:  alu_op = 3'b010;
          OP_OR:   alu_op = 3'b011;
          OP_NOT:  alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase

    if (boundary) state_next = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      wait_cnt_reg  <= 8'd0;
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
      retired_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (wait_clr)           wait_cnt_reg <= 8'd0;
      else if (wait_inc)      wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (set_illegal)        illegal_reg   <= 1'b1;
      if (set_bus_error)      bus_error_reg <= 1'b1;
      if (retire_en)          retired_reg   <= retired_reg + RETIRE_W'(1);
    end
  end

  assign state     = state_reg;
  assign halted    = (state_reg == S_HALT);
  assign illegal   = illegal_reg;
  assign bus_error = bus_error_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_accum_cpu_seq_ctrl.sv
// Cycle-level scoreboard bench for accum_cpu_seq_ctrl: stimulus queues the
// expected output snapshot per cycle, an independent monitor pops and compares.
module tb_accum_cpu_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       acc_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_load, pc_inc, pc_src, ld_ac, ac_src, mReadFlag, mWriteFlag;
  logic       halted, illegal, bus_error;
  logic [2:0] alu_op, state;
  logic [7:0] retired;

  accum_cpu_seq_ctrl #(.MEM_TIMEOUT(15), .RETIRE_W(8)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .acc_zero(acc_zero), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_src(pc_src), .ld_ac(ld_ac),
    .ac_src(ac_src), .alu_op(alu_op), .mReadFlag(mReadFlag), .mWriteFlag(mWriteFlag),
    .state(state), .halted(halted), .illegal(illegal), .bus_error(bus_error),
    .retired(retired)
  );

  always #5 clock = ~clock;

  // Snapshot layout: {state, ir_load, pc_inc, pc_src, ld_ac, ac_src, alu_op,
  //                   mRead, mWrite, halted, illegal, bus_error, retired}
  localparam logic [4:0] SB_F = 5'b11000, SB_J = 5'b00100, SB_LD = 5'b00010, SB_ALU = 5'b00011;
  localparam logic [1:0] RW_R = 2'b10, RW_W = 2'b01;

  logic [23:0] exp_q[$];
  string       name_q[$];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [23:0] ex(input logic [2:0] st, input logic [4:0] sb,
                                     input logic [2:0] alu, input logic [1:0] rw,
                                     input logic [2:0] stat, input logic [7:0] ret);
    return {st, sb, alu, rw, stat, ret};
  endfunction

  task automatic step(input logic [3:0] op, input logic rn, input logic az,
                      input logic mr, input logic [23:0] e, input string nm);
    @(negedge clock);
    reset = 1'b0; opcode = op; run = rn; acc_zero = az; mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic rst_cycle(input logic rn);
    @(negedge clock);
    reset = 1'b1; run = rn; mem_ready = 1'b0;
  endtask

  // Monitor: every cycle with a queued expectation is one transaction.
  initial begin
    logic [23:0] got, e;
    string nm;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {state, ir_load, pc_inc, pc_src, ld_ac, ac_src, alu_op,
               mReadFlag, mWriteFlag, halted, illegal, bus_error, retired};
        tests++;
        if (got !== e) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        end else begin
          $display("[TB] %s: %h ok", nm, got);
        end
      end
    end
  end

  initial begin
    rst_cycle(1'b0);
    @(negedge clock);
    reset = 1'b1; run = 1'b1;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0)); name_q.push_back("reset_idle");

    // NOP, NOP, HLT
    step(4'h0, 1, 0, 0, ex(0, 0,    0, 0, 3'b000, 0), "idle_run");
    step(4'h0, 1, 0, 0, ex(1, SB_F, 0, 0, 3'b000, 0), "f_nop1");
    step(4'h0, 1, 0, 0, ex(2, 0,    0, 0, 3'b000, 0), "d_nop1");
    step(4'h0, 1, 0, 0, ex(1, SB_F, 0, 0, 3'b000, 1), "f_nop2");
    step(4'h0, 1, 0, 0, ex(2, 0,    0, 0, 3'b000, 1), "d_nop2");
    step(4'hF, 1, 0, 0, ex(1, SB_F, 0, 0, 3'b000, 2), "f_hlt");
    step(4'hF, 1, 0, 0, ex(2, 0,    0, 0, 3'b000, 2), "d_hlt");
    step(4'hF, 1, 0, 0, ex(5, 0,    0, 0, 3'b100, 3), "halt");
    step(4'hF, 0, 0, 0, ex(5, 0,    0, 0, 3'b100, 3), "halt_run0");
    step(4'hF, 1, 0, 0, ex(5, 0,    0, 0, 3'b100, 3), "halt_run1");

    // ADD with zero wait, STA with three wait cycles, JZ taken / not taken
    rst_cycle(1'b1);
    step(4'h3, 1, 0, 1, ex(0, 0,      0, 0,    3'b000, 0), "idle2");
    step(4'h3, 1, 0, 1, ex(1, SB_F,   0, 0,    3'b000, 0), "f_add");
    step(4'h3, 1, 0, 1, ex(2, 0,      0, 0,    3'b000, 0), "d_add");
    step(4'h3, 1, 0, 1, ex(3, 0,      0, RW_R, 3'b000, 0), "m_add");
    step(4'h3, 1, 0, 1, ex(4, SB_ALU, 0, 0,    3'b000, 0), "e_add");
    step(4'h2, 1, 0, 0, ex(1, SB_F,   0, 0,    3'b000, 1), "f_sta");
    step(4'h2, 1, 0, 0, ex(2, 0,      0, 0,    3'b000, 1), "d_sta");
    for (int i = 0; i < 3; i++)
      step(4'h2, 1, 0, 0, ex(3, 0, 0, RW_W, 3'b000, 1), "m_sta_wait");
    step(4'h2, 1, 0, 1, ex(3, 0,    0, RW_W, 3'b000, 1), "m_sta_ok");
    step(4'h9, 1, 1, 0, ex(1, SB_F, 0, 0,    3'b000, 2), "f_jz1");
    step(4'h9, 1, 1, 0, ex(2, SB_J, 0, 0,    3'b000, 2), "d_jz1");
    step(4'h9, 1, 0, 0, ex(1, SB_F, 0, 0,    3'b000, 3), "f_jz0");
    step(4'h9, 1, 0, 0, ex(2, 0,    0, 0,    3'b000, 3), "d_jz0");

    // LDA timeout: 16 MEM cycles then HALT with bus_error
    step(4'h1, 1, 0, 0, ex(1, SB_F, 0, 0, 3'b000, 4), "f_lda");
    step(4'h1, 1, 0, 0, ex(2, 0,    0, 0, 3'b000, 4), "d_lda");
    for (int i = 0; i < 16; i++)
      step(4'h1, 1, 0, 0, ex(3, 0, 0, RW_R, 3'b000, 4), "m_lda_to");
    step(4'h1, 1, 0, 0, ex(5, 0, 0, 0, 3'b101, 4), "halt_buserr");

    // LDA with mem_ready arriving in the 16th MEM cycle
    rst_cycle(1'b1);
    step(4'h1, 1, 0, 0, ex(0, 0,    0, 0, 3'b000, 0), "idle3");
    step(4'h1, 1, 0, 0, ex(1, SB_F, 0, 0, 3'b000, 0), "f_lda2");
    step(4'h1, 1, 0, 0, ex(2, 0,    0, 0, 3'b000, 0), "d_lda2");
    for (int i = 0; i < 15; i++)
      step(4'h1, 1, 0, 0, ex(3, 0, 0, RW_R, 3'b000, 0), "m_lda2_wait");
    step(4'h1, 1, 0, 1, ex(3, 0,     0, RW_R, 3'b000, 0), "m_lda2_last");
    step(4'h1, 1, 0, 0, ex(4, SB_LD, 0, 0,    3'b000, 0), "e_lda2");

    // Illegal opcode B, then LDA with run dropped during MEM
    step(4'hB, 1, 0, 0, ex(1, SB_F,  0, 0,    3'b000, 1), "f_ill");
    step(4'hB, 1, 0, 0, ex(2, 0,     0, 0,    3'b000, 1), "d_ill");
    step(4'h1, 1, 0, 0, ex(1, SB_F,  0, 0,    3'b010, 2), "f_lda3");
    step(4'h1, 1, 0, 0, ex(2, 0,     0, 0,    3'b010, 2), "d_lda3");
    step(4'h1, 0, 0, 0, ex(3, 0,     0, RW_R, 3'b010, 2), "m_lda3_wait");
    step(4'h1, 0, 0, 1, ex(3, 0,     0, RW_R, 3'b010, 2), "m_lda3_ok");
    step(4'h1, 0, 0, 0, ex(4, SB_LD, 0, 0,    3'b010, 2), "e_lda3");
    step(4'h1, 0, 0, 0, ex(0, 0,     0, 0,    3'b010, 3), "idle_stop");
    step(4'h1, 1, 0, 0, ex(0, 0,     0, 0,    3'b010, 3), "idle_go");
    step(4'h1, 1, 0, 0, ex(1, SB_F,  0, 0,    3'b010, 3), "f_lda4");
    step(4'h1, 1, 0, 0, ex(2, 0,     0, 0,    3'b010, 3), "d_lda4");
    rst_cycle(1'b1);

    // After mid-MEM reset: NOT, JMP, SUB
    step(4'h7, 1, 0, 0, ex(0, 0,      0,      0,    3'b000, 0), "reset_mid");
    step(4'h7, 1, 0, 0, ex(1, SB_F,   0,      0,    3'b000, 0), "f_not");
    step(4'h7, 1, 0, 0, ex(2, 0,      0,      0,    3'b000, 0), "d_not");
    step(4'h7, 1, 0, 0, ex(4, SB_ALU, 3'b100, 0,    3'b000, 0), "e_not");
    step(4'h8, 1, 0, 0, ex(1, SB_F,   0,      0,    3'b000, 1), "f_jmp");
    step(4'h8, 1, 0, 0, ex(2, SB_J,   0,      0,    3'b000, 1), "d_jmp");
    step(4'h4, 1, 0, 1, ex(1, SB_F,   0,      0,    3'b000, 2), "f_sub");
    step(4'h4, 1, 0, 1, ex(2, 0,      0,      0,    3'b000, 2), "d_sub");
    step(4'h4, 1, 0, 1, ex(3, 0,      0,      RW_R, 3'b000, 2), "m_sub");
    step(4'h4, 1, 0, 1, ex(4, SB_ALU, 3'b001, 0,    3'b000, 2), "e_sub");
    step(4'h0, 1, 0, 0, ex(1, SB_F,   0,      0,    3'b000, 3), "f_end");

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
